// File: rtl/demorgan_sweep.sv
// demorgan_sweep
// Exhaustive De Morgan equivalence checker. On a start pulse it walks every
// combination of two WIDTH-bit operands, evaluates both sides of the selected
// identity and counts word-level mismatches. Each evaluated vector is streamed
// out on vec_* so it can be printed as a truth table. At the end it reports
// pass/fail, the saturating error count and the first failing operand pair.
// A fault-injection input flips rhs[0] on the diagonal (A == B). This lets
// the checker prove that it can actually detect a failure.

module demorgan_sweep #(
   parameter int WIDTH = 2,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic             inject,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] first_fail_a,
   output logic [WIDTH-1:0] first_fail_b,
   output logic             vec_valid,
   output logic [WIDTH-1:0] vec_a,
   output logic [WIDTH-1:0] vec_b,
   output logic [WIDTH-1:0] vec_lhs,
   output logic [WIDTH-1:0] vec_rhs
);

   // The vector counter holds both operands: A in the upper half, B in the lower half.
   localparam int CNT_W = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_LAST = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             mode_q;
   logic             inject_q;
   logic             fail_seen;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] lhs;
   logic [WIDTH-1:0] rhs;
   logic             mismatch;
   logic             last_vec;
   logic             err_full;
   logic             final_clean;

   assign op_a = cnt[CNT_W-1:WIDTH];
   assign op_b = cnt[WIDTH-1:0];

   // Both sides of the identity come combinationally from the counter. The
   // optional fault flips bit 0 of the right-hand side on the diagonal only.
   always_comb begin
      lhs = '0;
      rhs = '0;
      if (mode_q == 1'b0) begin
         lhs = ~(op_a | op_b);
         rhs = ~op_a & ~op_b;
      end else begin
         lhs = ~(op_a & op_b);
         rhs = ~op_a | ~op_b;
      end
      if (inject_q && (op_a == op_b)) begin
         rhs[0] = ~rhs[0];
      end
   end

   // Mismatch is a whole-word compare. The final verdict also folds in the
   // vector being evaluated on the last sweep edge.
   assign mismatch    = (lhs != rhs);
   assign last_vec    = (cnt == CNT_LAST);
   assign err_full    = &err_count;
   assign final_clean = (err_count == '0) && !mismatch;

   // Main controller: the state machine, vector counter, result capture and
   // the registered per-vector output stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         mode_q       <= 1'b0;
         inject_q     <= 1'b0;
         fail_seen    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         err_count    <= '0;
         first_fail_a <= '0;
         first_fail_b <= '0;
         vec_valid    <= 1'b0;
         vec_a        <= '0;
         vec_b        <= '0;
         vec_lhs      <= '0;
         vec_rhs      <= '0;
      end else begin
         done      <= 1'b0;
         vec_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= SWEEP;
                  busy         <= 1'b1;
                  mode_q       <= mode;
                  inject_q     <= inject;
                  cnt          <= '0;
                  err_count    <= '0;
                  fail_seen    <= 1'b0;
                  first_fail_a <= '0;
                  first_fail_b <= '0;
                  pass         <= 1'b0;
               end
            end
            SWEEP: begin
               vec_valid <= 1'b1;
               vec_a     <= op_a;
               vec_b     <= op_b;
               vec_lhs   <= lhs;
               vec_rhs   <= rhs;
               if (mismatch) begin
                  if (!err_full) begin
                     err_count <= err_count + ERR_W'(1);
                  end
                  if (!fail_seen) begin
                     fail_seen    <= 1'b1;
                     first_fail_a <= op_a;
                     first_fail_b <= op_b;
                  end
               end
               cnt <= cnt + CNT_W'(1);
               if (last_vec) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= final_clean;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_demorgan_sweep.sv
// tb_demorgan_sweep
// Scoreboard bench for demorgan_sweep with three instances (WIDTH 1, 2 and 3
// with a 2-bit error counter). Stimulus pushes the expected vector stream and
// the end-of-sweep summary into queues. Per-instance monitors pop and compare
// whenever vec_valid or done is presented.
`timescale 1ns/1ps

module tb_demorgan_sweep;

   typedef struct {
      int a;
      int b;
      int lhs;
      int rhs;
   } vec_exp_t;

   typedef struct {
      int pass_v;
      int err;
      int ffa;
      int ffb;
      int done_cyc;
   } sum_exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic mode;
   logic inject;
   logic start1, start2, start3;

   logic       busy1, done1, pass1, vv1;
   logic [7:0] err1;
   logic [0:0] ffa1, ffb1, va1, vb1, vl1, vr1;

   logic       busy2, done2, pass2, vv2;
   logic [7:0] err2;
   logic [1:0] ffa2, ffb2, va2, vb2, vl2, vr2;

   logic       busy3, done3, pass3, vv3;
   logic [1:0] err3;
   logic [2:0] ffa3, ffb3, va3, vb3, vl3, vr3;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   vec_exp_t vq1[$];
   vec_exp_t vq2[$];
   vec_exp_t vq3[$];
   sum_exp_t sq1[$];
   sum_exp_t sq2[$];
   sum_exp_t sq3[$];

   vec_exp_t ev1, ev2, ev3;
   sum_exp_t es1, es2, es3;

   // Free-running clock and cycle counter used to time done pulses.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   demorgan_sweep #(.WIDTH(1), .ERR_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .inject(inject),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail_a(ffa1), .first_fail_b(ffb1), .vec_valid(vv1),
      .vec_a(va1), .vec_b(vb1), .vec_lhs(vl1), .vec_rhs(vr1)
   );

   demorgan_sweep #(.WIDTH(2), .ERR_W(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .inject(inject),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .first_fail_a(ffa2), .first_fail_b(ffb2), .vec_valid(vv2),
      .vec_a(va2), .vec_b(vb2), .vec_lhs(vl2), .vec_rhs(vr2)
   );

   demorgan_sweep #(.WIDTH(3), .ERR_W(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode), .inject(inject),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
      .first_fail_a(ffa3), .first_fail_b(ffb3), .vec_valid(vv3),
      .vec_a(va3), .vec_b(vb3), .vec_lhs(vl3), .vec_rhs(vr3)
   );

   // One comparison: bumps the check count and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference value of one vector, written directly from the two identities.
   function automatic vec_exp_t model_vec(input int w, input int k, input bit m, input bit inj);
      vec_exp_t e;
      int mask;
      mask = (1 << w) - 1;
      e.a = (k >> w) & mask;
      e.b = k & mask;
      if (!m) begin
         e.lhs = (~(e.a | e.b)) & mask;
         e.rhs = ((~e.a) & (~e.b)) & mask;
      end else begin
         e.lhs = (~(e.a & e.b)) & mask;
         e.rhs = ((~e.a) | (~e.b)) & mask;
      end
      if (inj && (e.a == e.b)) e.rhs = e.rhs ^ 1;
      return e;
   endfunction

   // Queue the expected vector stream for one sweep of the selected instance.
   task automatic pushVectors(input int which, input bit m, input bit inj);
      vec_exp_t e;
      int tbl[4][4];
      tbl = '{'{0, 0, 1, 1}, '{0, 1, 0, 0}, '{1, 0, 0, 0}, '{1, 1, 0, 0}};
      if (which == 1) begin
         for (int k = 0; k < 4; k++) begin
            if (!m && !inj) begin
               e.a = tbl[k][0]; e.b = tbl[k][1]; e.lhs = tbl[k][2]; e.rhs = tbl[k][3];
            end else begin
               e = model_vec(1, k, m, inj);
            end
            vq1.push_back(e);
         end
      end else if (which == 2) begin
         for (int k = 0; k < 16; k++) vq2.push_back(model_vec(2, k, m, inj));
      end else begin
         for (int k = 0; k < 64; k++) vq3.push_back(model_vec(3, k, m, inj));
      end
   endtask

   // Pulse start on one instance and queue its expected stream and summary.
   task automatic applyStimulus(input int which, input bit m, input bit inj,
                                input int exp_pass, input int exp_err,
                                input int exp_ffa, input int exp_ffb,
                                output int s_cyc);
      sum_exp_t s;
      int n;
      @(negedge clk);
      mode   = m;
      inject = inj;
      if (which == 1) start1 = 1'b1;
      else if (which == 2) start2 = 1'b1;
      else start3 = 1'b1;
      @(posedge clk);
      #1;
      s_cyc  = cyc;
      start1 = 1'b0;
      start2 = 1'b0;
      start3 = 1'b0;
      n = (which == 1) ? 4 : ((which == 2) ? 16 : 64);
      pushVectors(which, m, inj);
      s.pass_v = exp_pass; s.err = exp_err; s.ffa = exp_ffa; s.ffb = exp_ffb;
      s.done_cyc = s_cyc + n;
      if (which == 1) sq1.push_back(s);
      else if (which == 2) sq2.push_back(s);
      else sq3.push_back(s);
   endtask

   // Wait, with a cycle budget, until every queued summary has been consumed.
   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while ((sq1.size() + sq2.size() + sq3.size()) != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      checkOutput("drain_summaries_left", sq1.size() + sq2.size() + sq3.size(), 0);
      checkOutput("drain_vectors_left", vq1.size() + vq2.size() + vq3.size(), 0);
      @(posedge clk);
   endtask

   // Monitor for the WIDTH=1 instance.
   always @(negedge clk) begin
      if (vv1) begin
         if (vq1.size() == 0) checkOutput("dut1_unexpected_vec", 1, 0);
         else begin
            ev1 = vq1.pop_front();
            checkOutput("dut1_vec_a", va1, ev1.a);
            checkOutput("dut1_vec_b", vb1, ev1.b);
            checkOutput("dut1_vec_lhs", vl1, ev1.lhs);
            checkOutput("dut1_vec_rhs", vr1, ev1.rhs);
         end
      end
      if (done1) begin
         if (sq1.size() == 0) checkOutput("dut1_unexpected_done", 1, 0);
         else begin
            es1 = sq1.pop_front();
            checkOutput("dut1_pass", pass1, es1.pass_v);
            checkOutput("dut1_err_count", err1, es1.err);
            checkOutput("dut1_first_fail_a", ffa1, es1.ffa);
            checkOutput("dut1_first_fail_b", ffb1, es1.ffb);
            checkOutput("dut1_done_cycle", cyc, es1.done_cyc);
         end
      end
   end

   // Monitor for the WIDTH=2 instance.
   always @(negedge clk) begin
      if (vv2) begin
         if (vq2.size() == 0) checkOutput("dut2_unexpected_vec", 1, 0);
         else begin
            ev2 = vq2.pop_front();
            checkOutput("dut2_vec_a", va2, ev2.a);
            checkOutput("dut2_vec_b", vb2, ev2.b);
            checkOutput("dut2_vec_lhs", vl2, ev2.lhs);
            checkOutput("dut2_vec_rhs", vr2, ev2.rhs);
         end
      end
      if (done2) begin
         if (sq2.size() == 0) checkOutput("dut2_unexpected_done", 1, 0);
         else begin
            es2 = sq2.pop_front();
            checkOutput("dut2_pass", pass2, es2.pass_v);
            checkOutput("dut2_err_count", err2, es2.err);
            checkOutput("dut2_first_fail_a", ffa2, es2.ffa);
            checkOutput("dut2_first_fail_b", ffb2, es2.ffb);
            checkOutput("dut2_done_cycle", cyc, es2.done_cyc);
         end
      end
   end

   // Monitor for the WIDTH=3, ERR_W=2 instance.
   always @(negedge clk) begin
      if (vv3) begin
         if (vq3.size() == 0) checkOutput("dut3_unexpected_vec", 1, 0);
         else begin
            ev3 = vq3.pop_front();
            checkOutput("dut3_vec_a", va3, ev3.a);
            checkOutput("dut3_vec_b", vb3, ev3.b);
            checkOutput("dut3_vec_lhs", vl3, ev3.lhs);
            checkOutput("dut3_vec_rhs", vr3, ev3.rhs);
         end
      end
      if (done3) begin
         if (sq3.size() == 0) checkOutput("dut3_unexpected_done", 1, 0);
         else begin
            es3 = sq3.pop_front();
            checkOutput("dut3_pass", pass3, es3.pass_v);
            checkOutput("dut3_err_count", err3, es3.err);
            checkOutput("dut3_first_fail_a", ffa3, es3.ffa);
            checkOutput("dut3_first_fail_b", ffb3, es3.ffb);
            checkOutput("dut3_done_cycle", cyc, es3.done_cyc);
         end
      end
   end

   // Hard time limit so the bench always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int s;
      int s2;
      sum_exp_t sm;
      rst_n  = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      start3 = 1'b0;
      mode   = 1'b0;
      inject = 1'b0;
      #12;
      checkOutput("reset_busy", busy2, 0);
      checkOutput("reset_done", done2, 0);
      checkOutput("reset_pass", pass2, 0);
      checkOutput("reset_err_count", err2, 0);
      checkOutput("reset_vec_valid", vv2, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] WIDTH=1 truth table sweep, mode 0");
      applyStimulus(1, 1'b0, 1'b0, 1, 0, 0, 0, s);
      checkOutput("w1_busy_c1", busy1, 1);
      waitDrain(50);

      $display("[TB] WIDTH=2 mode 1 with fault injection");
      applyStimulus(2, 1'b1, 1'b1, 0, 4, 0, 0, s);
      waitDrain(50);

      $display("[TB] WIDTH=3 ERR_W=2 saturation");
      applyStimulus(3, 1'b0, 1'b1, 0, 3, 0, 0, s);
      waitDrain(200);

      $display("[TB] start held high through a sweep");
      @(negedge clk);
      mode   = 1'b0;
      inject = 1'b1;
      start2 = 1'b1;
      @(posedge clk);
      #1;
      s = cyc;
      checkOutput("hold_busy_c1", busy2, 1);
      pushVectors(2, 1'b0, 1'b1);
      sm.pass_v = 0; sm.err = 4; sm.ffa = 0; sm.ffb = 0; sm.done_cyc = s + 16;
      sq2.push_back(sm);
      repeat (17) @(posedge clk);
      #1;
      checkOutput("hold_err_held_c18", err2, 4);
      checkOutput("hold_idle_c18_busy", busy2, 0);
      @(posedge clk);
      #1;
      s2 = cyc;
      start2 = 1'b0;
      checkOutput("hold_restart_cycle", s2 - s, 18);
      checkOutput("hold_restart_busy", busy2, 1);
      checkOutput("hold_restart_err_cleared", err2, 0);
      pushVectors(2, 1'b0, 1'b1);
      sm.done_cyc = s2 + 16;
      sq2.push_back(sm);
      waitDrain(60);

      $display("[TB] asynchronous reset mid-sweep");
      @(negedge clk);
      mode   = 1'b0;
      inject = 1'b1;
      start2 = 1'b1;
      @(posedge clk);
      #1;
      s = cyc;
      start2 = 1'b0;
      pushVectors(2, 1'b0, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("abort_err_before_reset", err2, 2);
      checkOutput("abort_busy_before_reset", busy2, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", busy2, 0);
      checkOutput("abort_err_count", err2, 0);
      checkOutput("abort_vec_valid", vv2, 0);
      checkOutput("abort_vec_lhs", vl2, 0);
      checkOutput("abort_pass", pass2, 0);
      vq2.delete();
      repeat (3) @(negedge clk);
      checkOutput("abort_no_done", done2, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("abort_stays_idle", busy2, 0);
      applyStimulus(2, 1'b0, 1'b0, 1, 0, 0, 0, s);
      waitDrain(50);

      $display("[TB] failing sweep followed by clean sweep");
      applyStimulus(2, 1'b0, 1'b1, 0, 4, 0, 0, s);
      waitDrain(50);
      applyStimulus(2, 1'b1, 1'b0, 1, 0, 0, 0, s);
      waitDrain(50);
      @(negedge clk);
      checkOutput("final_pass_held", pass2, 1);
      checkOutput("final_err_held", err2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
